// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: step modes, shift
// direction and sequencer states.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ARI  = 2'b01;
  localparam logic [1:0] MODE_ROT  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// One combinational shift step: computes the next register value and the
// bit ejected on the far side for the given direction and mode.
module univ_shift_reg_shift_step
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             si,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  logic fill;

  always_comb begin
    fill    = 1'b0;
    q_next  = q;
    out_bit = (dir == DIR_L) ? q[WIDTH-1] : q[0];
    if (dir == DIR_R) begin
      case (mode)
        MODE_LOG: fill = si;
        MODE_ARI: fill = q[WIDTH-1];
        MODE_ROT: fill = q[0];
        default:  fill = 1'b0;
      endcase
      if (mode != MODE_HOLD) q_next = {fill, q[WIDTH-1:1]};
    end else begin
      case (mode)
        MODE_LOG: fill = si;
        MODE_ARI: fill = 1'b0;
        MODE_ROT: fill = q[WIDTH-1];
        default:  fill = 1'b0;
      endcase
      if (mode != MODE_HOLD) q_next = {q[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with parallel load, single-step
// shifting and a multi-step sequencer reporting busy/done.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] db,
  input  logic             shb,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] qb,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  state_t           state, state_next;
  logic [AMT_W-1:0] cnt;
  logic             dir_r;
  logic [1:0]       mode_r;
  logic             step_dir;
  logic [1:0]       step_mode;
  logic [WIDTH-1:0] q_next;
  logic             out_bit;

  // SHIFT uses the settings latched at start; IDLE single steps use live ones.
  assign step_dir  = (state == SHIFT) ? dir_r  : dir;
  assign step_mode = (state == SHIFT) ? mode_r : mode;

  univ_shift_reg_shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (qb),
    .dir     (step_dir),
    .mode    (step_mode),
    .si      (si),
    .q_next  (q_next),
    .out_bit (out_bit)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!ld && start) state_next = (amt == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == AMT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (clr) begin
      qb     <= '0;
      so     <= 1'b0;
      cnt    <= '0;
      dir_r  <= DIR_R;
      mode_r <= MODE_LOG;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            qb <= db;
          end else if (start) begin
            if (amt != '0) begin
              dir_r  <= dir;
              mode_r <= mode;
              cnt    <= (amt > WIDTH_AMT) ? WIDTH_AMT : amt;
            end
          end else if (shb) begin
            qb <= q_next;
            if (mode != MODE_HOLD) so <= out_bit;
          end
        end
        SHIFT: begin
          qb  <= q_next;
          cnt <= cnt - AMT_W'(1);
          if (mode_r != MODE_HOLD) so <= out_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH=4 and WIDTH=8.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       clr4, ld4, shb4, dir4, si4, start4;
  logic [3:0] db4, qb4;
  logic [1:0] mode4;
  logic [2:0] amt4;
  logic       so4, busy4, done4;

  // WIDTH=8 instance
  logic       clr8, ld8, shb8, dir8, si8, start8;
  logic [7:0] db8, qb8;
  logic [1:0] mode8;
  logic [3:0] amt8;
  logic       so8, busy8, done8;

  univ_shift_reg #(.WIDTH(4)) u4 (
    .clk(clk), .clr(clr4), .ld(ld4), .db(db4), .shb(shb4), .dir(dir4),
    .mode(mode4), .si(si4), .start(start4), .amt(amt4),
    .qb(qb4), .so(so4), .busy(busy4), .done(done4)
  );

  univ_shift_reg #(.WIDTH(8)) u8 (
    .clk(clk), .clr(clr8), .ld(ld8), .db(db8), .shb(shb8), .dir(dir8),
    .mode(mode8), .si(si8), .start(start8), .amt(amt8),
    .qb(qb8), .so(so8), .busy(busy8), .done(done8)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] db;
    logic       shb;
    logic       dir;
    logic [1:0] mode;
    logic       si;
    logic [3:0] exp_qb;
    logic       exp_so;
  } vec_t;

  vec_t vecs[17];

  task automatic idle4;
    clr4 = 0; ld4 = 0; shb4 = 0; dir4 = 0; si4 = 0; start4 = 0;
    db4 = '0; mode4 = 2'b00; amt4 = '0;
  endtask

  task automatic idle8;
    clr8 = 0; ld8 = 0; shb8 = 0; dir8 = 0; si8 = 0; start8 = 0;
    db8 = '0; mode8 = 2'b00; amt8 = '0;
  endtask

  initial begin
    int nbusy;
    bit seen_done;

    //           ld db       shb dir mode   si  exp_qb   exp_so
    vecs[0]  = '{1, 4'b1001, 0, 0, 2'b00, 0, 4'b1001, 0};
    vecs[1]  = '{0, 4'b0000, 1, 0, 2'b00, 0, 4'b0100, 1};
    vecs[2]  = '{0, 4'b0000, 1, 0, 2'b00, 0, 4'b0010, 0};
    vecs[3]  = '{0, 4'b0000, 1, 0, 2'b00, 0, 4'b0001, 0};
    vecs[4]  = '{1, 4'b1010, 0, 0, 2'b00, 0, 4'b1010, 0};
    vecs[5]  = '{0, 4'b0000, 1, 0, 2'b01, 0, 4'b1101, 0};
    vecs[6]  = '{0, 4'b0000, 1, 0, 2'b01, 0, 4'b1110, 1};
    vecs[7]  = '{0, 4'b0000, 1, 1, 2'b00, 1, 4'b1101, 1};
    vecs[8]  = '{0, 4'b0000, 1, 1, 2'b01, 1, 4'b1010, 1};
    vecs[9]  = '{0, 4'b0000, 1, 0, 2'b10, 0, 4'b0101, 0};
    vecs[10] = '{0, 4'b0000, 1, 1, 2'b10, 0, 4'b1010, 0};
    vecs[11] = '{0, 4'b0000, 1, 1, 2'b11, 1, 4'b1010, 0};
    vecs[12] = '{0, 4'b0000, 1, 0, 2'b00, 1, 4'b1101, 0};
    vecs[13] = '{0, 4'b0000, 1, 1, 2'b10, 0, 4'b1011, 1};
    vecs[14] = '{1, 4'b0110, 1, 0, 2'b00, 0, 4'b0110, 1};
    vecs[15] = '{0, 4'b0000, 0, 1, 2'b00, 1, 4'b0110, 1};
    vecs[16] = '{0, 4'b0000, 1, 0, 2'b11, 1, 4'b0110, 1};

    idle4(); idle8();
    clr4 = 1; clr8 = 1;
    tick();
    clr4 = 0; clr8 = 0;
    check("reset_qb4", 32'(qb4), 32'h0);
    check("reset_so4", 32'(so4), 32'h0);
    check("reset_bd4", 32'({busy4, done4}), 32'h0);
    check("reset_qb8", 32'(qb8), 32'h0);

    // Single-step / load table on the 4-bit register
    for (int i = 0; i < 17; i++) begin
      ld4 = vecs[i].ld; db4 = vecs[i].db; shb4 = vecs[i].shb;
      dir4 = vecs[i].dir; mode4 = vecs[i].mode; si4 = vecs[i].si;
      tick();
      check($sformatf("vec%0d_qb", i), 32'(qb4), 32'(vecs[i].exp_qb));
      check($sformatf("vec%0d_so", i), 32'(so4), 32'(vecs[i].exp_so));
      check($sformatf("vec%0d_bd", i), 32'({busy4, done4}), 32'h0);
    end
    idle4();

    // clr overrides a simultaneous start/ld after activity
    clr4 = 1; start4 = 1; amt4 = 3'd2; ld4 = 1; db4 = 4'b1111;
    tick();
    idle4();
    check("clr_qb", 32'(qb4), 32'h0);
    check("clr_so", 32'(so4), 32'h0);
    check("clr_bd", 32'({busy4, done4}), 32'h0);

    // WIDTH=8 arithmetic right by 3, ld/shb/start during busy ignored
    ld8 = 1; db8 = 8'b10010110;
    tick();
    idle8();
    start8 = 1; amt8 = 4'd3; dir8 = 0; mode8 = 2'b01;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ari_busy%0d", i), 32'({busy8, done8}), 32'h2);
      ld8 = 1; db8 = 8'hFF; shb8 = 1; start8 = 1; amt8 = 4'd1;
      dir8 = 1; mode8 = 2'b00; si8 = 1;
      tick();
    end
    idle8();
    start8 = 1; amt8 = 4'd2; dir8 = 1; mode8 = 2'b10;
    check("ari_done", 32'({busy8, done8}), 32'h1);
    check("ari_qb", 32'(qb8), 32'hF2);
    check("ari_so", 32'(so8), 32'h1);
    tick();
    idle8();
    check("ari_after", 32'({busy8, done8}), 32'h0);
    check("ari_after_qb", 32'(qb8), 32'hF2);

    // WIDTH=8 rotate left, amt=9 clamps to 8
    ld8 = 1; db8 = 8'b10000001;
    tick();
    idle8();
    start8 = 1; amt8 = 4'd9; dir8 = 1; mode8 = 2'b10;
    tick();
    idle8();
    nbusy = 0; seen_done = 0;
    for (int i = 0; i < 12 && !seen_done; i++) begin
      if (done8) seen_done = 1;
      else begin
        if (busy8) nbusy++;
        tick();
      end
    end
    check("rot_done_seen", 32'(seen_done), 32'h1);
    check("rot_busy_cnt", 32'(nbusy), 32'd8);
    check("rot_qb", 32'(qb8), 32'h81);
    check("rot_so", 32'(so8), 32'h1);

    // WIDTH=4 amt=0: done next cycle, busy never high
    ld4 = 1; db4 = 4'b1011;
    tick();
    idle4();
    start4 = 1; amt4 = 3'd0; dir4 = 1; mode4 = 2'b00;
    tick();
    idle4();
    check("amt0_done", 32'({busy4, done4}), 32'h1);
    check("amt0_qb", 32'(qb4), 32'hB);
    tick();
    check("amt0_after", 32'({busy4, done4}), 32'h0);

    // WIDTH=4 clr during the 2nd busy cycle aborts without done
    ld4 = 1; db4 = 4'b0101;
    tick();
    idle4();
    start4 = 1; amt4 = 3'd4; dir4 = 0; mode4 = 2'b00;
    tick();
    idle4();
    check("abort_busy1", 32'(busy4), 32'h1);
    tick();
    check("abort_busy2", 32'(busy4), 32'h1);
    clr4 = 1;
    tick();
    clr4 = 0;
    check("abort_qb", 32'(qb4), 32'h0);
    check("abort_so", 32'(so4), 32'h0);
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done4 || busy4) seen_done = 1;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 32'h0);

    // WIDTH=4 serial stream fed during SHIFT
    ld4 = 1; db4 = 4'b0000;
    tick();
    idle4();
    start4 = 1; amt4 = 3'd4; dir4 = 1; mode4 = 2'b00;
    tick();
    idle4();
    si4 = 1; tick();
    si4 = 0; tick();
    si4 = 1; tick();
    si4 = 1; tick();
    si4 = 0;
    check("ser_done", 32'({busy4, done4}), 32'h1);
    check("ser_qb", 32'(qb4), 32'hB);
    check("ser_so", 32'(so4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
